icache_refill: RTL and testbench

- Miss-side refill engine for the instruction cache; it is the writer that drives the per-way set RAMs (128-bit sets, 256 sets, 8-bit set address).
- Accepts a miss physical address from the lookup pipeline and issues one line request to memory.
- Assembles the two 64-bit response beats into a 128-bit set, then writes that set plus its tag into a round-robin victim way in a single cycle.
- Pulses completion back to the lookup pipeline.

---
 rtl/icache_refill.sv | 135 +++++++++++++
 tb/tb_icache_refill.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill.sv
// Purpose : instruction-cache miss refill engine. It takes one miss, issues one line
//           request, packs two 64-bit beats into one 128-bit set and writes that set
//           into a round-robin victim way.
// Latency : at least 4 cycles from the miss handshake to refill_done_o. The REQ stall
//           and the gaps between beats add to this.
// Backpr. : miss_ready_o is low outside IDLE. mem_req is held until it is accepted.
//           Response beats cannot be stalled.
// Ports   : miss_* is the miss handshake from lookup, and kill_i is a pipeline flush.
//           mem_req_* is the line request; mem_resp_* carries the beats.
//           way_* is the single-cycle write port to the way RAMs.
//           refill_done_o pulses for one cycle when the line is written.
module icache_refill #(
    parameter int PADDR_WIDTH = 40,
    parameter int NUM_WAYS    = 4,
    parameter int WORD_SIZE   = 64,
    parameter int SET_WIDTH   = 128,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    miss_valid_i,
    input  logic [PADDR_WIDTH-1:0]  miss_paddr_i,
    output logic                    miss_ready_o,
    input  logic                    kill_i,
    output logic                    mem_req_valid_o,
    input  logic                    mem_req_ready_i,
    output logic [PADDR_WIDTH-1:0]  mem_req_addr_o,
    input  logic                    mem_resp_valid_i,
    input  logic [WORD_SIZE-1:0]    mem_resp_data_i,
    output logic [NUM_WAYS-1:0]     way_req_o,
    output logic                    way_we_o,
    output logic [ADDR_WIDTH-1:0]   way_addr_o,
    output logic [SET_WIDTH-1:0]    way_data_o,
    output logic [PADDR_WIDTH-13:0] way_tag_o,
    output logic                    refill_done_o
);

    localparam int VW = $clog2(NUM_WAYS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_RESP  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;

    logic [2:0]             state;
    logic [VW-1:0]          victim;
    logic                   beat_cnt;
    logic [SET_WIDTH-1:0]   line;
    logic [PADDR_WIDTH-1:0] paddr_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= S_IDLE;
            victim   <= '0;
            beat_cnt <= 1'b0;
            line     <= '0;
            paddr_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // A kill in the same cycle as the handshake does not abort the miss.
                    // Beats that arrive here are protocol errors and are dropped.
                    beat_cnt <= 1'b0;
                    if (miss_valid_i) begin
                        paddr_q <= miss_paddr_i;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready_i) begin
                        // Once memory accepts, both beats will arrive.
                        // A kill at this point must still drain them.
                        beat_cnt <= 1'b0;
                        state    <= kill_i ? S_DRAIN : S_RESP;
                    end else if (kill_i) begin
                        state <= S_IDLE;
                    end
                end
                S_RESP: begin
                    if (kill_i) begin
                        // A beat that arrives in the kill cycle counts toward the drain.
                        if (mem_resp_valid_i && beat_cnt) begin
                            beat_cnt <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt | mem_resp_valid_i;
                            state    <= S_DRAIN;
                        end
                    end else if (mem_resp_valid_i) begin
                        if (!beat_cnt) begin
                            line[WORD_SIZE-1:0] <= mem_resp_data_i;
                            beat_cnt            <= 1'b1;
                        end else begin
                            line[SET_WIDTH-1:WORD_SIZE] <= mem_resp_data_i;
                            beat_cnt                    <= 1'b0;
                            state                       <= S_WRITE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (mem_resp_valid_i) begin
                        if (beat_cnt) begin
                            beat_cnt <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            beat_cnt <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    // NUM_WAYS is a power of two, so the pointer wraps on its own.
                    victim <= victim + 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign miss_ready_o    = (state == S_IDLE);
    assign mem_req_valid_o = (state == S_REQ);
    assign mem_req_addr_o  = paddr_q & ~PADDR_WIDTH'(15);

    assign way_we_o      = (state == S_WRITE);
    assign refill_done_o = (state == S_WRITE);
    assign way_req_o     = (state == S_WRITE) ? (NUM_WAYS'(1) << victim) : '0;

    // These outputs come straight from registers. They are only meaningful in
    // WRITE, but they never go X.
    assign way_addr_o = paddr_q[11:4];
    assign way_data_o = line;
    assign way_tag_o  = paddr_q[PADDR_WIDTH-1:12];

endmodule

// File: tb/tb_icache_refill.sv
module tb_icache_refill;

    localparam int P  = 40;
    localparam int NW = 4;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           miss_valid = 1'b0;
    logic [P-1:0]   miss_paddr = '0;
    logic           miss_ready;
    logic           kill = 1'b0;
    logic           mem_req_valid;
    logic           mem_req_ready = 1'b0;
    logic [P-1:0]   mem_req_addr;
    logic           resp_valid = 1'b0;
    logic [63:0]    resp_data = '0;
    logic [NW-1:0]  way_req;
    logic           way_we;
    logic [7:0]     way_addr;
    logic [127:0]   way_data;
    logic [P-13:0]  way_tag;
    logic           refill_done;

    typedef struct packed {
        logic [NW-1:0] way;
        logic [7:0]    addr;
        logic [127:0]  data;
        logic [P-13:0] tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;
    int   model_victim = 0;

    icache_refill dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .miss_valid_i     (miss_valid),
        .miss_paddr_i     (miss_paddr),
        .miss_ready_o     (miss_ready),
        .kill_i           (kill),
        .mem_req_valid_o  (mem_req_valid),
        .mem_req_ready_i  (mem_req_ready),
        .mem_req_addr_o   (mem_req_addr),
        .mem_resp_valid_i (resp_valid),
        .mem_resp_data_i  (resp_data),
        .way_req_o        (way_req),
        .way_we_o         (way_we),
        .way_addr_o       (way_addr),
        .way_data_o       (way_data),
        .way_tag_o        (way_tag),
        .refill_done_o    (refill_done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Monitor: check the write-port control on every cycle and compare each
    // way write against the scoreboard.
    always @(negedge clk) begin
        if (rstn) begin
            checks++;
            if (refill_done !== way_we || (way_we !== 1'b1 && way_req !== '0))
                $display("FAIL ctrl: done=%b we=%b req=%b required done==we and req=0 outside write",
                         refill_done, way_we, way_req);
            else
                passes++;
            if (way_we === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_write: req=%b addr=%h, none expected", way_req, way_addr);
                end else begin
                    mon_e = sb.pop_front();
                    if ({way_req, way_addr, way_data, way_tag} !== mon_e)
                        $display("FAIL write: got req=%b addr=%h data=%h tag=%h required req=%b addr=%h data=%h tag=%h",
                                 way_req, way_addr, way_data, way_tag,
                                 mon_e.way, mon_e.addr, mon_e.data, mon_e.tag);
                    else
                        passes++;
                end
            end
        end
    end

    task automatic push_exp(input logic [P-1:0] pa, input logic [63:0] d0, input logic [63:0] d1);
        exp_t e;
        e.way  = NW'(1 << model_victim);
        e.addr = pa[11:4];
        e.data = {d1, d0};
        e.tag  = pa[P-1:12];
        sb.push_back(e);
        model_victim = (model_victim + 1) % NW;
    endtask

    task automatic do_miss(input logic [P-1:0] pa);
        int n = 0;
        while (miss_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (miss_ready !== 1'b1) $display("FAIL miss_ready_wait: miss_ready=%b required 1", miss_ready);
        else passes++;
        miss_valid = 1'b1;
        miss_paddr = pa;
        @(posedge clk); #1;
        miss_valid = 1'b0;
    endtask

    task automatic accept(input int stall, input logic [P-1:0] pa);
        logic [P-1:0] ea;
        ea = {pa[P-1:4], 4'h0};
        for (int i = 0; i <= stall; i++) begin
            @(negedge clk);
            checks++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== ea || miss_ready !== 1'b0)
                $display("FAIL req_hold: valid=%b addr=%h miss_ready=%b required 1 %h 0",
                         mem_req_valid, mem_req_addr, miss_ready, ea);
            else
                passes++;
            if (i == stall) mem_req_ready = 1'b1;
            @(posedge clk); #1;
        end
        mem_req_ready = 1'b0;
    endtask

    task automatic beat(input logic [63:0] d, input int gap);
        repeat (gap) begin
            @(posedge clk); #1;
        end
        resp_valid = 1'b1;
        resp_data  = d;
        @(posedge clk); #1;
        resp_valid = 1'b0;
        resp_data  = '0;
    endtask

    task automatic refill(input logic [P-1:0] pa, input logic [63:0] d0, input logic [63:0] d1,
                          input int stall, input int gap);
        push_exp(pa, d0, d1);
        do_miss(pa);
        accept(stall, pa);
        beat(d0, 0);
        beat(d1, gap);
        @(negedge clk);
        checks++;
        if (refill_done !== 1'b1) $display("FAIL done_timing: refill_done=%b required 1", refill_done);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (miss_ready !== 1'b1 ||
            {mem_req_valid, mem_req_addr, way_req, way_we, way_addr, way_data, way_tag, refill_done} !== '0)
            $display("FAIL %s: miss_ready=%b req_valid=%b req_addr=%h way_req=%b we=%b data=%h done=%b required 1 and all 0",
                     tag, miss_ready, mem_req_valid, mem_req_addr, way_req, way_we, way_data, refill_done);
        else
            passes++;
    endtask

    task automatic test_reset();
        #3;
        check_reset_outputs("reset_state");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        refill(40'h00_0000_1A38, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 0, 0);
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 5; i++)
            refill({8'h00, $urandom(), 4'h0} | P'(i * 8),
                   {$urandom(), $urandom()}, {$urandom(), $urandom()}, 0, 0);
    endtask

    task automatic test_backpressure();
        refill(40'h12_3456_7FF8, 64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002, 3, 2);
    endtask

    task automatic test_kill_req();
        do_miss(40'h00_0000_5550);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        checks++;
        if (miss_ready !== 1'b1 || mem_req_valid !== 1'b0)
            $display("FAIL kill_req: miss_ready=%b req_valid=%b required 1 0", miss_ready, mem_req_valid);
        else
            passes++;
        // The victim must not have advanced.
        refill(40'h00_0000_6660, 64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A, 0, 0);
    endtask

    task automatic test_kill_resp();
        do_miss(40'h00_0000_7770);
        accept(0, 40'h00_0000_7770);
        beat(64'hBAD0_BAD0_BAD0_BAD0, 0);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        checks++;
        if (miss_ready !== 1'b0) $display("FAIL kill_resp_drain: miss_ready=%b required 0", miss_ready);
        else passes++;
        beat(64'hBAD1_BAD1_BAD1_BAD1, 1);
        checks++;
        if (miss_ready !== 1'b1) $display("FAIL kill_resp_idle: miss_ready=%b required 1", miss_ready);
        else passes++;
        refill(40'h00_0000_8880, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 0, 1);
    endtask

    task automatic test_kill_accept();
        do_miss(40'h00_0000_9990);
        @(negedge clk);
        kill = 1'b1;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        mem_req_ready = 1'b0;
        beat(64'hBAD2_BAD2_BAD2_BAD2, 0);
        checks++;
        if (miss_ready !== 1'b0) $display("FAIL kill_accept_drain: miss_ready=%b required 0", miss_ready);
        else passes++;
        beat(64'hBAD3_BAD3_BAD3_BAD3, 0);
        checks++;
        if (miss_ready !== 1'b1) $display("FAIL kill_accept_idle: miss_ready=%b required 1", miss_ready);
        else passes++;
    endtask

    task automatic test_stray_beat();
        beat(64'hFFFF_FFFF_FFFF_FFFF, 0);
        checks++;
        if (miss_ready !== 1'b1) $display("FAIL stray_beat: miss_ready=%b required 1", miss_ready);
        else passes++;
        refill(40'hFF_FFFF_F000, 64'h0000_0000_0000_0042, 64'h0000_0000_0000_0043, 1, 0);
    endtask

    task automatic test_async_reset();
        do_miss(40'h00_0000_ABC0);
        accept(0, 40'h00_0000_ABC0);
        beat(64'h7777_7777_7777_7777, 0);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_victim = 0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        // The in-flight second beat shows up in IDLE and must be ignored.
        beat(64'h8888_8888_8888_8888, 0);
        refill(40'h00_0000_0010, 64'h1234_0000_0000_0001, 64'h1234_0000_0000_0002, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_backpressure();
        test_kill_req();
        test_kill_resp();
        test_kill_accept();
        test_stray_beat();
        test_async_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d writes missing, required 0", sb.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
